// File: rtl/rv32i_pipeline_core.sv
// rtl/rv32i_pipeline_core.sv - RV32I 5-stage pipelined integer core (IF/ID/EX/MEM/WB)
// Bus outputs come straight from the PC and EX/MEM registers.

module rv32i_ram_2r_w (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    // Register i lives at mem[32i+31:32i]; slot 0 is never written so x0 reads 0.
    logic [1023:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we && waddr != 5'd0) begin
            mem[{waddr, 5'b0} +: 32] <= wdata;
        end
    end

    assign rdata1 = mem[{raddr1, 5'b0} +: 32];
    assign rdata2 = mem[{raddr2, 5'b0} +: 32];
endmodule

module rv32i_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] ram_rdata1;
    logic [31:0] ram_rdata2;

    rv32i_ram_2r_w u_DW_ram_2r_w_s_dff (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (ram_rdata1),
        .rdata2 (ram_rdata2)
    );

    // Write-before-read: the WB value is visible to the ID read in the same cycle.
    assign rdata1 = (we && waddr == raddr1 && raddr1 != 5'd0) ? wdata : ram_rdata1;
    assign rdata2 = (we && waddr == raddr2 && raddr2 != 5'd0) ? wdata : ram_rdata2;
endmodule

module rv32i_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acki_n,
    input  logic        ackd_n,
    input  logic [31:0] idt,
    input  logic [31:0] ddt_in,
    output logic [31:0] iad,
    output logic [31:0] dad,
    output logic        mreq,
    output logic        write,
    output logic [1:0]  size,
    output logic [31:0] ddt_out
);
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_pc;
    logic        idex_valid;
    logic [31:0] idex_instr, idex_pc, idex_rs1_val, idex_rs2_val;
    logic        exmem_regwrite, exmem_load, exmem_store;
    logic [4:0]  exmem_rd;
    logic [2:0]  exmem_funct3;
    logic [1:0]  exmem_size;
    logic [31:0] exmem_result, exmem_store_data;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;

    logic        mem_stall, rf_we;

    // ---------------- ID ----------------
    logic [6:0]  id_opc;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_rs1_val, id_rs2_val;
    logic        id_uses_rs1, id_uses_rs2, load_use;

    assign id_opc = ifid_instr[6:0];
    assign id_rs1 = ifid_instr[19:15];
    assign id_rs2 = ifid_instr[24:20];

    always_comb begin
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        if (ifid_valid) begin
            case (id_opc)
                OPC_JALR, OPC_LOAD, OPC_OPIMM: id_uses_rs1 = 1'b1;
                OPC_BRANCH, OPC_STORE, OPC_OP: begin
                    id_uses_rs1 = 1'b1;
                    id_uses_rs2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    rv32i_regfile rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (memwb_rd),
        .wdata  (memwb_result),
        .raddr1 (id_rs1),
        .raddr2 (id_rs2),
        .rdata1 (id_rs1_val),
        .rdata2 (id_rs2_val)
    );

    // ---------------- EX ----------------
    logic [6:0]  ex_opc;
    logic [2:0]  ex_f3;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic        ex_alt, ex_is_load, ex_is_store, ex_regwrite, ex_br_cond, ex_redirect;
    logic [31:0] ex_a, ex_b_fwd, ex_b, ex_imm, ex_alu, ex_result, ex_target, ex_store_data;
    logic [1:0]  ex_size;

    assign ex_opc = idex_instr[6:0];
    assign ex_f3  = idex_instr[14:12];
    assign ex_rd  = idex_instr[11:7];
    assign ex_rs1 = idex_instr[19:15];
    assign ex_rs2 = idex_instr[24:20];

    // A waiting consumer of a load must not enter EX until the load has left MEM.
    assign ex_is_load  = idex_valid && ex_opc == OPC_LOAD;
    assign ex_is_store = idex_valid && ex_opc == OPC_STORE;
    assign load_use = ex_is_load && ex_rd != 5'd0 &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

    always_comb begin
        ex_a = idex_rs1_val;
        if (exmem_regwrite && exmem_rd == ex_rs1) ex_a = exmem_result;
        else if (memwb_regwrite && memwb_rd == ex_rs1) ex_a = memwb_result;
        ex_b_fwd = idex_rs2_val;
        if (exmem_regwrite && exmem_rd == ex_rs2) ex_b_fwd = exmem_result;
        else if (memwb_regwrite && memwb_rd == ex_rs2) ex_b_fwd = memwb_result;
    end

    always_comb begin
        case (ex_opc)
            OPC_STORE:           ex_imm = {{20{idex_instr[31]}}, idex_instr[31:25], idex_instr[11:7]};
            OPC_BRANCH:          ex_imm = {{19{idex_instr[31]}}, idex_instr[31], idex_instr[7],
                                           idex_instr[30:25], idex_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:  ex_imm = {idex_instr[31:12], 12'b0};
            OPC_JAL:             ex_imm = {{11{idex_instr[31]}}, idex_instr[31], idex_instr[19:12],
                                           idex_instr[20], idex_instr[30:21], 1'b0};
            default:             ex_imm = {{20{idex_instr[31]}}, idex_instr[31:20]};
        endcase
    end

    // Bit 30 selects SUB/SRA for OP, but only SRAI among the immediates.
    assign ex_b   = (ex_opc == OPC_OP) ? ex_b_fwd : ex_imm;
    assign ex_alt = idex_instr[30] && (ex_opc == OPC_OP || ex_f3 == 3'b101);

    always_comb begin
        case (ex_f3)
            3'b000:  ex_alu = ex_alt ? ex_a - ex_b : ex_a + ex_b;
            3'b001:  ex_alu = ex_a << ex_b[4:0];
            3'b010:  ex_alu = {31'b0, $signed(ex_a) < $signed(ex_b)};
            3'b011:  ex_alu = {31'b0, ex_a < ex_b};
            3'b100:  ex_alu = ex_a ^ ex_b;
            3'b101:  ex_alu = ex_alt ? $unsigned($signed(ex_a) >>> ex_b[4:0]) : ex_a >> ex_b[4:0];
            3'b110:  ex_alu = ex_a | ex_b;
            default: ex_alu = ex_a & ex_b;
        endcase
    end

    always_comb begin
        case (ex_f3)
            3'b000:  ex_br_cond = ex_a == ex_b_fwd;
            3'b001:  ex_br_cond = ex_a != ex_b_fwd;
            3'b100:  ex_br_cond = $signed(ex_a) < $signed(ex_b_fwd);
            3'b101:  ex_br_cond = $signed(ex_a) >= $signed(ex_b_fwd);
            3'b110:  ex_br_cond = ex_a < ex_b_fwd;
            3'b111:  ex_br_cond = ex_a >= ex_b_fwd;
            default: ex_br_cond = 1'b0;
        endcase
    end

    always_comb begin
        ex_redirect = 1'b0;
        ex_regwrite = 1'b0;
        ex_result   = ex_alu;
        ex_target   = idex_pc + ex_imm;
        case (ex_opc)
            OPC_LUI: begin
                ex_result   = ex_imm;
                ex_regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                ex_result   = idex_pc + ex_imm;
                ex_regwrite = 1'b1;
            end
            OPC_JAL: begin
                ex_result   = idex_pc + 32'd4;
                ex_regwrite = 1'b1;
                ex_redirect = 1'b1;
            end
            OPC_JALR: begin
                ex_result   = idex_pc + 32'd4;
                ex_regwrite = 1'b1;
                ex_redirect = 1'b1;
                ex_target   = (ex_a + ex_imm) & ~32'd1;
            end
            OPC_BRANCH: ex_redirect = ex_br_cond;
            OPC_LOAD: begin
                ex_result   = ex_a + ex_imm;
                ex_regwrite = 1'b1;
            end
            OPC_STORE:  ex_result = ex_a + ex_imm;
            OPC_OPIMM, OPC_OP: ex_regwrite = 1'b1;
            default: ;
        endcase
        if (!idex_valid || ex_rd == 5'd0) ex_regwrite = 1'b0;
        if (!idex_valid) ex_redirect = 1'b0;
    end

    always_comb begin
        ex_size       = 2'b00;
        ex_store_data = ex_b_fwd;
        if (ex_is_load || ex_is_store) begin
            case (ex_f3[1:0])
                2'b00: begin
                    ex_size       = 2'b10;
                    ex_store_data = {24'b0, ex_b_fwd[7:0]};
                end
                2'b01: begin
                    ex_size       = 2'b01;
                    ex_store_data = {16'b0, ex_b_fwd[15:0]};
                end
                default: ;
            endcase
        end
    end

    // ---------------- MEM / WB ----------------
    logic [31:0] mem_load_val, wb_data;

    assign mem_stall = (exmem_load || exmem_store) && ackd_n;

    always_comb begin
        case (exmem_funct3)
            3'b000:  mem_load_val = {{24{ddt_in[7]}}, ddt_in[7:0]};
            3'b001:  mem_load_val = {{16{ddt_in[15]}}, ddt_in[15:0]};
            3'b100:  mem_load_val = {24'b0, ddt_in[7:0]};
            3'b101:  mem_load_val = {16'b0, ddt_in[15:0]};
            default: mem_load_val = ddt_in;
        endcase
    end

    assign wb_data = exmem_load ? mem_load_val : exmem_result;
    // MEM/WB is frozen during a data stall; write only once, on the releasing edge.
    assign rf_we   = memwb_regwrite && !mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc               <= RESET_PC;
            ifid_valid       <= 1'b0;
            ifid_instr       <= NOP;
            ifid_pc          <= '0;
            idex_valid       <= 1'b0;
            idex_instr       <= NOP;
            idex_pc          <= '0;
            idex_rs1_val     <= '0;
            idex_rs2_val     <= '0;
            exmem_regwrite   <= 1'b0;
            exmem_load       <= 1'b0;
            exmem_store      <= 1'b0;
            exmem_rd         <= '0;
            exmem_funct3     <= '0;
            exmem_size       <= '0;
            exmem_result     <= '0;
            exmem_store_data <= '0;
            memwb_regwrite   <= 1'b0;
            memwb_rd         <= '0;
            memwb_result     <= '0;
        end else if (!mem_stall) begin
            if (ex_redirect) begin
                pc         <= ex_target;
                ifid_valid <= 1'b0;
            end else if (!load_use) begin
                if (!acki_n) begin
                    ifid_valid <= 1'b1;
                    ifid_instr <= idt;
                    ifid_pc    <= pc;
                    pc         <= pc + 32'd4;
                end else begin
                    ifid_valid <= 1'b0;
                end
            end

            if (ex_redirect || load_use) begin
                idex_valid <= 1'b0;
            end else begin
                idex_valid   <= ifid_valid;
                idex_instr   <= ifid_instr;
                idex_pc      <= ifid_pc;
                idex_rs1_val <= id_rs1_val;
                idex_rs2_val <= id_rs2_val;
            end

            exmem_regwrite   <= ex_regwrite;
            exmem_load       <= ex_is_load;
            exmem_store      <= ex_is_store;
            exmem_rd         <= ex_rd;
            exmem_funct3     <= ex_f3;
            exmem_size       <= ex_size;
            exmem_result     <= ex_result;
            exmem_store_data <= ex_store_data;

            memwb_regwrite   <= exmem_regwrite;
            memwb_rd         <= exmem_rd;
            memwb_result     <= wb_data;
        end
    end

    assign iad     = pc;
    assign dad     = exmem_result;
    assign mreq    = exmem_load || exmem_store;
    assign write   = exmem_store;
    assign size    = exmem_size;
    assign ddt_out = exmem_store_data;
endmodule

module rv32i_pipeline_core #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ACKI_n,
    input  logic            ACKD_n,
    input  logic [XLEN-1:0] IDT,
    input  logic [2:0]      OINT_n,
    output logic [XLEN-1:0] IAD,
    output logic [XLEN-1:0] DAD,
    output logic            MREQ,
    output logic            WRITE,
    output logic [1:0]      SIZE,
    output logic            IACK_n,
    inout  wire  [XLEN-1:0] DDT
);
    logic [XLEN-1:0] ddt_out;
    logic            unused_oint;

    rv32i_datapath #(
        .RESET_PC (RESET_PC)
    ) datapath (
        .clk     (clk),
        .rst_n   (rst),
        .acki_n  (ACKI_n),
        .ackd_n  (ACKD_n),
        .idt     (IDT),
        .ddt_in  (DDT),
        .iad     (IAD),
        .dad     (DAD),
        .mreq    (MREQ),
        .write   (WRITE),
        .size    (SIZE),
        .ddt_out (ddt_out)
    );

    // Interrupts are not supported.
    assign unused_oint = ^OINT_n;
    assign IACK_n      = 1'b1;
    assign DDT         = (MREQ && WRITE) ? ddt_out : {XLEN{1'bz}};
endmodule

// File: tb/tb_rv32i_pipeline_core.sv
// tb/tb_rv32i_pipeline_core.sv - directed table-driven bench for rv32i_pipeline_core

module tb_rv32i_pipeline_core;
    logic        clk;
    logic        rst;
    logic        ACKI_n;
    logic        ACKD_n;
    logic [31:0] IDT;
    logic [2:0]  OINT_n;
    logic [31:0] IAD;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        IACK_n;
    wire  [31:0] DDT;

    logic [31:0] imem [64];
    logic [31:0] load_data;
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    rv32i_pipeline_core dut (
        .clk    (clk),
        .rst    (rst),
        .ACKI_n (ACKI_n),
        .ACKD_n (ACKD_n),
        .IDT    (IDT),
        .OINT_n (OINT_n),
        .IAD    (IAD),
        .DAD    (DAD),
        .MREQ   (MREQ),
        .WRITE  (WRITE),
        .SIZE   (SIZE),
        .IACK_n (IACK_n),
        .DDT    (DDT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign IDT = imem[IAD[7:2]];
    assign DDT = (MREQ && !WRITE) ? load_data : 32'bz;

    typedef struct packed {
        logic [5:0][31:0] prog;
        logic [31:0]      ld;
        logic [4:0]       rd;
        logic [31:0]      exp;
    } vec_t;
    vec_t tv [$];

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm[11:0], rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction
    function automatic logic [31:0] auipc(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h17};
    endfunction
    function automatic logic [31:0] op(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] load(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
        return enc_i(imm, rs1, f3, rd, 7'h03);
    endfunction
    function automatic logic [31:0] store(input logic [2:0] f3, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] get_reg(input int r);
        return dut.datapath.rf.u_DW_ram_2r_w_s_dff.mem[r*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                           input logic [31:0] i3, input logic [31:0] ld, input logic [4:0] rd,
                           input logic [31:0] exp);
        vec_t v;
        v.prog[0] = i0;
        v.prog[1] = i1;
        v.prog[2] = i2;
        v.prog[3] = i3;
        v.prog[4] = NOP;
        v.prog[5] = NOP;
        v.ld  = ld;
        v.rd  = rd;
        v.exp = exp;
        tv.push_back(v);
    endtask

    task automatic load_prog(input logic [5:0][31:0] prog);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        for (int i = 0; i < 6; i++) imem[i] = prog[i];
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_mreq(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (MREQ) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [5:0][31:0] p;
        logic             ok;
        rst = 1'b0; ACKI_n = 1'b0; ACKD_n = 1'b0; OINT_n = 3'b111; load_data = '0;
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        repeat (2) @(negedge clk);

        check("reset_iad",   IAD, 32'h0);
        check("reset_dad",   DAD, 32'h0);
        check("reset_mreq",  {31'b0, MREQ}, 32'h0);
        check("reset_write", {31'b0, WRITE}, 32'h0);
        check("reset_size",  {30'b0, SIZE}, 32'h0);
        check("reset_iack",  {31'b0, IACK_n}, 32'h1);

        // Fetch sequence 0,4,8, then an instruction-ack stall holds the PC.
        rst = 1'b1;
        #1 check("iad_seq0", IAD, 32'h0);
        @(negedge clk) check("iad_seq4", IAD, 32'h4);
        @(negedge clk) check("iad_seq8", IAD, 32'h8);
        ACKI_n = 1'b1;
        @(negedge clk) check("iad_acki_hold", IAD, 32'h8);
        ACKI_n = 1'b0;
        @(negedge clk) check("iad_acki_resume", IAD, 32'hC);

        add_vec(addi(1, 0, 5), addi(2, 1, 7), NOP, NOP, 0, 2, 32'd12);
        add_vec(lui(1, 20'h80000), enc_i(32'h404, 1, 3'b101, 2, 7'h13), NOP, NOP, 0, 2, 32'hF800_0000);
        add_vec(lui(1, 20'h80000), enc_i(32'h004, 1, 3'b101, 2, 7'h13), NOP, NOP, 0, 2, 32'h0800_0000);
        add_vec(addi(1, 0, -3), addi(2, 0, 2), op(7'h00, 3'b010, 3, 1, 2), NOP, 0, 3, 32'd1);
        add_vec(addi(1, 0, -3), addi(2, 0, 2), op(7'h00, 3'b011, 3, 1, 2), NOP, 0, 3, 32'd0);
        add_vec(addi(1, 0, 10), addi(2, 0, 3), op(7'h20, 3'b000, 3, 2, 1), NOP, 0, 3, 32'hFFFF_FFF9);
        add_vec(load(3'b000, 7, 0, 0), NOP, NOP, NOP, 32'h0000_00F0, 7, 32'hFFFF_FFF0);
        add_vec(load(3'b100, 7, 0, 0), NOP, NOP, NOP, 32'h0000_00F0, 7, 32'h0000_00F0);
        add_vec(load(3'b001, 7, 0, 0), NOP, NOP, NOP, 32'h0000_8001, 7, 32'hFFFF_8001);
        add_vec(load(3'b010, 8, 0, 0), op(7'h00, 3'b000, 9, 8, 8), NOP, NOP, 32'd3, 9, 32'd6);
        add_vec(beq(0, 0, 12), addi(10, 0, 1), addi(10, 0, 1), addi(11, 0, 2), 0, 10, 32'd0);
        add_vec(beq(0, 0, 12), addi(10, 0, 1), addi(10, 0, 1), addi(11, 0, 2), 0, 11, 32'd2);
        add_vec(jal(1, 8), addi(5, 0, 1), addi(6, 0, 9), NOP, 0, 1, 32'd4);
        add_vec(jal(1, 8), addi(5, 0, 1), addi(6, 0, 9), NOP, 0, 5, 32'd0);
        add_vec(addi(0, 0, 5), addi(3, 0, 1), op(7'h00, 3'b000, 4, 0, 3), NOP, 0, 4, 32'd1);
        add_vec(addi(1, 0, 3), NOP, op(7'h00, 3'b000, 2, 1, 1), NOP, 0, 2, 32'd6);
        add_vec(addi(1, 0, 3), NOP, NOP, op(7'h00, 3'b000, 2, 1, 1), 0, 2, 32'd6);
        add_vec(NOP, auipc(1, 20'h00001), NOP, NOP, 0, 1, 32'h0000_1004);
        add_vec(addi(1, 0, 13), enc_i(0, 1, 3'b000, 2, 7'h67), addi(3, 0, 1), addi(4, 0, 7), 0, 2, 32'd8);
        add_vec(addi(1, 0, 13), enc_i(0, 1, 3'b000, 2, 7'h67), addi(3, 0, 1), addi(4, 0, 7), 0, 3, 32'd0);
        add_vec(addi(1, 0, 13), enc_i(0, 1, 3'b000, 2, 7'h67), addi(3, 0, 1), addi(4, 0, 7), 0, 4, 32'd7);

        for (int v = 0; v < tv.size(); v++) begin
            load_data = tv[v].ld;
            load_prog(tv[v].prog);
            repeat (25) @(negedge clk);
            check($sformatf("vec%0d_x%0d", v, tv[v].rd), get_reg(int'(tv[v].rd)), tv[v].exp);
        end

        // Console byte store.
        p = '{default: NOP};
        p[0] = addi(5, 0, 32'h41);
        p[1] = lui(6, 20'hF0000);
        p[2] = store(3'b000, 5, 6, 0);
        load_prog(p);
        wait_mreq(ok);
        check("sb_mreq_seen", {31'b0, ok}, 32'h1);
        check("sb_write", {31'b0, WRITE}, 32'h1);
        check("sb_size",  {30'b0, SIZE}, 32'h2);
        check("sb_dad",   DAD, 32'hF000_0000);
        check("sb_ddt",   DDT, 32'h0000_0041);
        @(negedge clk) check("sb_single", {31'b0, MREQ}, 32'h0);

        // Data-ack stall on a load with a dependent consumer; x1 must still reach the RF.
        p = '{default: NOP};
        p[0] = addi(1, 0, 1);
        p[1] = load(3'b010, 8, 0, 4);
        p[2] = op(7'h00, 3'b000, 9, 8, 1);
        load_data = 32'h0000_0100;
        ACKD_n = 1'b1;
        load_prog(p);
        wait_mreq(ok);
        check("lw_mreq_seen", {31'b0, ok}, 32'h1);
        repeat (3) @(negedge clk);
        check("lw_stall_mreq", {31'b0, MREQ}, 32'h1);
        check("lw_stall_dad",  DAD, 32'h4);
        check("lw_stall_iad",  IAD, 32'hC);
        ACKD_n = 1'b0;
        repeat (10) @(negedge clk);
        check("lw_stall_x1", get_reg(1), 32'd1);
        check("lw_stall_x9", get_reg(9), 32'h0000_0101);

        // Exit store, then reset while the store is on the bus.
        p = '{default: NOP};
        p[0] = lui(6, 20'hFF000);
        p[1] = store(3'b010, 0, 6, 0);
        load_prog(p);
        wait_mreq(ok);
        check("sw_mreq_seen", {31'b0, ok}, 32'h1);
        check("sw_write", {31'b0, WRITE}, 32'h1);
        check("sw_size",  {30'b0, SIZE}, 32'h0);
        check("sw_dad",   DAD, 32'hFF00_0000);
        check("sw_ddt",   DDT, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("rst_async_iad",  IAD, 32'h0);
        check("rst_async_mreq", {31'b0, MREQ}, 32'h0);
        check("rst_rf_clear",   get_reg(6), 32'h0);
        @(negedge clk) check("rst_hold_mreq", {31'b0, MREQ}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv32i_pipeline_core.md
Name: rv32i_pipeline_core

Overview:
- 32-bit RISC-V RV32I integer core with a classic 5-stage pipeline (IF, ID, EX, MEM, WB).
- Sits at the top of the processor hierarchy. It connects to an external instruction memory (IAD/IDT/ACKI_n) and an external data memory (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Memory-mapped I/O is handled outside the core: a byte store to 0xF0000000 is console output; any store to 0xFF000000 is program exit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, data, address and instruction width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ACKI_n  in  1  instruction acknowledge, active low; IDT is valid when 0.
- ACKD_n  in  1  data acknowledge, active low; a MEM-stage access completes when 0.
- IDT  in  32  instruction word for address IAD; used as the RV32I encoding directly.
- OINT_n  in  3  external interrupt requests, active low; ignored (no interrupt support).
- IAD  out  32  instruction fetch address (PC of the IF stage).
- DAD  out  32  data byte address (MEM stage).
- MREQ  out  1  data access request (load or store in MEM stage).
- WRITE  out  1  1 = store, 0 = load; valid only while MREQ=1.
- SIZE  out  2  access size: 00 word, 01 half, 10 byte.
- IACK_n  out  1  interrupt acknowledge; held at 1.
- DDT  inout  32  data bus.
  - Core drives it only while MREQ=1 and WRITE=1; high-Z otherwise.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-low.
  - While rst=0: PC=RESET_PC; all pipeline registers hold bubbles (NOP); register file cleared to 0.
  - Output values in reset: IAD=0, DAD=0, MREQ=0, WRITE=0, SIZE=00, DDT=Z, IACK_n=1.
  - Reset asserted mid-run discards all in-flight instructions. No store may be issued after the reset edge.
- Output timing:
  - IAD, DAD, MREQ, WRITE, SIZE and DDT (on writes) come straight from registers (PC, EX/MEM). They are stable for the whole cycle after a rising edge.
  - The environment samples them mid-cycle and returns IDT/DDT before the next rising edge.
- IF stage:
  - IDT is captured into IF/ID at the rising edge when ACKI_n=0.
  - PC advances by 4 unless stalled or redirected.
  - If ACKI_n=1: PC holds and a bubble enters ID.
- ISA: full RV32I except FENCE, ECALL, EBREAK and CSR instructions; these execute as NOP.
  - Covered: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP.
  - x0 always reads 0; writes to x0 are discarded.
- Register file:
  - 32x32, two read ports, one write port.
  - The WB write is visible to an ID read in the same cycle (write-before-read bypass).
  - Instance path datapath.rf.u_DW_ram_2r_w_s_dff.mem: one packed 1024-bit vector, register i at bits [32i+31:32i]. This path is a verification hook and is mandatory.
- Hazards:
  - Forwarding into EX operands from EX/MEM and from MEM/WB. EX/MEM has priority.
  - Load-use: one-cycle stall. Hold PC and IF/ID; bubble into EX.
  - Branches and jumps resolve in EX. When taken, flush IF/ID and ID/EX (2-cycle penalty).
  - JALR target is (rs1+imm) with bit 0 cleared.
- Data bus, MEM stage:
  - DAD = full byte address rs1+imm. MREQ=1 for loads and stores only.
  - Store data positions:
    - SW: DDT[31:0] = rs2.
    - SH: DDT[15:0] = rs2[15:0], upper bits 0.
    - SB: DDT[7:0] = rs2[7:0], upper bits 0.
  - Load data is returned in DDT[31:0] (word), DDT[15:0] (half) or DDT[7:0] (byte). The core sign- or zero-extends it per the opcode and captures it into MEM/WB at the rising edge.
  - MEM access with ACKD_n=1 at the rising edge: the whole pipeline stalls and the access repeats. No duplicate register writeback is allowed.
  - No misalignment traps; the address is passed through as is.
- Arithmetic:
  - All arithmetic is 32-bit, wrap-around; overflow is ignored.
  - Shifts use the low 5 bits of the shift amount. SRA/SRAI are arithmetic shifts.
  - SLT is signed; SLTU is unsigned.
  - Immediates are sign-extended per RV32I format.

Test Plan:
- Reset then ADDI x1,x0,5; ADDI x2,x1,7 (back-to-back) -> forwarding gives x2=12; IAD sequence 0,4,8 after reset release.
- LI x5,0x41; LUI x6,0xF0000; SB x5,0(x6) -> MEM cycle shows MREQ=1, WRITE=1, SIZE=10, DAD=0xF0000000, DDT[7:0]=0x41.
- LB x7 with memory returning DDT=0x000000F0 -> x7=0xFFFFFFF0; LBU -> 0x000000F0; LH with DDT=0x00008001 -> 0xFFFF8001.
- LW x8 followed by ADD x9,x8,x8 with DDT=0x00000003 -> one stall bubble, x9=6.
- BEQ x0,x0,+12 with ADDI x10,x0,1 in the two following slots -> x10 stays 0; fetch continues at target.
- SW x0 to 0xFF000000 -> MREQ=1, WRITE=1, SIZE=00, DAD=0xFF000000. Assert rst mid-run -> IAD=0 and MREQ=0 immediately.
